// File: rtl/md_pkg.sv
// Shared definitions for the MIPS E-stage multiply/divide unit.
// Optional multiply-accumulate ops are enabled by MD_UNIT_MADD_EN.
package md_pkg;

    localparam int unsigned MD_OP_W = 4;
    localparam int unsigned XLEN    = 32;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
    localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;
    localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd10;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } md_hilo_t;

    // Ops that open a MULT_CYCLES busy window.
    function automatic logic md_is_mul(input logic [MD_OP_W-1:0] op);
`ifdef MD_UNIT_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
               (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath: 64-bit pending HI/LO result and divide-by-zero flag.
// Multiply-accumulate variants are built only with MD_UNIT_MADD_EN.
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    input  md_hilo_t           hilo_in,
    output md_hilo_t           res_c,
    output logic               div_by_zero_c
);

    logic signed [2*XLEN-1:0] sa_ext;
    logic signed [2*XLEN-1:0] sb_ext;
    logic [2*XLEN-1:0]        prod_s;
    logic [2*XLEN-1:0]        prod_u;
    logic [XLEN-1:0]          divisor;
    logic [XLEN-1:0]          abs_a;
    logic [XLEN-1:0]          abs_b;
    logic [XLEN-1:0]          mag_q;
    logic [XLEN-1:0]          mag_r;
    logic [XLEN-1:0]          uq;
    logic [XLEN-1:0]          ur;

    always_comb begin
        sa_ext        = (2*XLEN)'($signed(a));
        sb_ext        = (2*XLEN)'($signed(b));
        prod_s        = sa_ext * sb_ext;
        prod_u        = {XLEN'(0), a} * {XLEN'(0), b};
        div_by_zero_c = (b == '0);
        divisor       = div_by_zero_c ? XLEN'(1) : b;

        // Signed divide on magnitudes so INT_MIN / -1 wraps instead of trapping.
        abs_a = a[XLEN-1] ? -a : a;
        abs_b = divisor[XLEN-1] ? -divisor : divisor;
        mag_q = abs_a / abs_b;
        mag_r = abs_a % abs_b;
        uq    = a / divisor;
        ur    = a % divisor;

        res_c = hilo_in;
        case (op)
            MD_MULT:  res_c = prod_s;
            MD_MULTU: res_c = prod_u;
            MD_DIV: begin
                if (!div_by_zero_c) begin
                    res_c.lo = (a[XLEN-1] ^ b[XLEN-1]) ? -mag_q : mag_q;
                    res_c.hi = a[XLEN-1] ? -mag_r : mag_r;
                end
            end
            MD_DIVU: begin
                if (!div_by_zero_c) begin
                    res_c.lo = uq;
                    res_c.hi = ur;
                end
            end
`ifdef MD_UNIT_MADD_EN
            MD_MADD:  res_c = hilo_in + prod_s;
            MD_MADDU: res_c = hilo_in + prod_u;
            MD_MSUB:  res_c = hilo_in - prod_s;
            MD_MSUBU: res_c = hilo_in - prod_u;
`endif
            default:  res_c = hilo_in;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, busy window FSM, mfhi/mflo read port.
// Build with MD_UNIT_MADD_EN to add madd/maddu/msub/msubu.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    input  logic               rd_hi,
    output logic               busy,
    output logic [XLEN-1:0]    hi,
    output logic [XLEN-1:0]    lo,
    output logic [XLEN-1:0]    md_out
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_hilo_t        hilo_q, hilo_d;
    md_hilo_t        pend_q, pend_d;
    logic            dbz_q, dbz_d;

    md_hilo_t        res_c;
    logic            div_by_zero_c;
    logic            is_mul_c;
    logic            is_div_c;

    md_arith u_arith (
        .op            (md_op),
        .a             (a),
        .b             (b),
        .hilo_in       (hilo_q),
        .res_c         (res_c),
        .div_by_zero_c (div_by_zero_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hilo_q  <= '0;
            pend_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hilo_q  <= hilo_d;
            pend_q  <= pend_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state: launch captures the result immediately; HI/LO update at window end.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hilo_d   = hilo_q;
        pend_d   = pend_q;
        dbz_d    = dbz_q;
        is_mul_c = md_is_mul(md_op);
        is_div_c = md_is_div(md_op);

        case (state_q)
            ST_IDLE: begin
                if (start && (is_mul_c || is_div_c)) begin
                    pend_d  = res_c;
                    dbz_d   = is_div_c && div_by_zero_c;
                    cnt_d   = is_div_c ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                    state_d = ST_BUSY;
                end else if (md_op == MD_MTHI) begin
                    hilo_d.hi = a;
                end else if (md_op == MD_MTLO) begin
                    hilo_d.lo = a;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    if (!dbz_q) begin
                        hilo_d = pend_q;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy   = (state_q == ST_BUSY);
    assign hi     = hilo_q.hi;
    assign lo     = hilo_q.lo;
    assign md_out = rd_hi ? hilo_q.hi : hilo_q.lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops against a reference model.
module tb_md_unit;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hi;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .rd_hi  (rd_hi),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: architectural effect of one issued op from the MIPS rules.
    function automatic void model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                                  input bit st, input logic [31:0] h, input logic [31:0] l,
                                  output int n, output logic [31:0] nh, output logic [31:0] nl);
        longint      sp;
        logic [63:0] up;
        logic [63:0] acc;
        int          sa;
        int          sb;
        n  = 0;
        nh = h;
        nl = l;
        sp = longint'($signed(av)) * longint'($signed(bv));
        up = {32'd0, av} * {32'd0, bv};
        acc = {h, l};
        sa = av;
        sb = bv;
        if (op == MD_MTHI) nh = av;
        else if (op == MD_MTLO) nl = av;
        else if (st) begin
            case (op)
                MD_MULT:  begin n = MC; {nh, nl} = 64'(sp); end
                MD_MULTU: begin n = MC; {nh, nl} = up; end
                MD_DIV: begin
                    n = DC;
                    if (bv == 0) begin end
                    else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin nl = av; nh = 0; end
                    else begin nl = 32'(sa / sb); nh = 32'(sa % sb); end
                end
                MD_DIVU: begin
                    n = DC;
                    if (bv != 0) begin nl = av / bv; nh = av % bv; end
                end
`ifdef MD_UNIT_MADD_EN
                MD_MADD:  begin n = MC; {nh, nl} = acc + 64'(sp); end
                MD_MADDU: begin n = MC; {nh, nl} = acc + up; end
                MD_MSUB:  begin n = MC; {nh, nl} = acc - 64'(sp); end
                MD_MSUBU: begin n = MC; {nh, nl} = acc - up; end
`endif
                default: ;
            endcase
        end
    endfunction

    // Issue one op, measure the busy window, then check HI/LO and the read port.
    task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input bit st, input int exp_n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input string tag);
        int n;
        @(negedge clk);
        md_op = op; a = av; b = bv; start = st;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = MD_NONE;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy"}, 64'(n), 64'(exp_n));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        rd_hi = 1'($urandom_range(0, 1));
        #1;
        check({tag, "_mdout"}, 64'(md_out), 64'(rd_hi ? exp_hi : exp_lo));
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          n;
        int          en;
        logic [31:0] eh;
        logic [31:0] el;
        logic [3:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        bit          st;

        reset = 1'b0; start = 1'b0; md_op = MD_NONE; a = '0; b = '0; rd_hi = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1, MC, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_op(MD_DIVU,  32'd7,         32'd2, 1'b1, DC, 32'd1,         32'd3,         "divu");
        run_op(MD_MTHI,  32'h11,        32'd0, 1'b0, 0,  32'h11,        32'd3,         "mthi11");
        run_op(MD_MTLO,  32'h22,        32'd0, 1'b1, 0,  32'h11,        32'h22,        "mtlo22");
        run_op(MD_DIV,   32'd5,         32'd0, 1'b1, DC, 32'h11,        32'h22,        "div0");
        run_op(MD_DIVU,  32'd9,         32'd0, 1'b1, DC, 32'h11,        32'h22,        "divu0");
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, DC, 32'h0, 32'h8000_0000, "div_ovf");
        run_op(MD_MULT,  32'd4,         32'd4, 1'b0, 0,  32'h0,         32'h8000_0000, "mult_nostart");
        run_op(MD_MTHI,  32'hABCD,      32'd0, 1'b0, 0,  32'hABCD,      32'h8000_0000, "mthi");
        run_op(MD_MTLO,  32'h1234,      32'd0, 1'b0, 0,  32'hABCD,      32'h1234,      "mtlo");
        rd_hi = 1'b1; #1;
        check("mdout_hi", 64'(md_out), 64'(32'hABCD));
        rd_hi = 1'b0; #1;
        check("mdout_lo", 64'(md_out), 64'(32'h1234));

        // Events arriving mid-window must not disturb the in-flight multiply.
        @(negedge clk);
        md_op = MD_MULT; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = MD_NONE;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 2) begin start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7; end
            else if (n == 3) begin start = 1'b0; md_op = MD_MTHI; a = 32'hDEAD; end
            else begin start = 1'b0; md_op = MD_NONE; end
            @(negedge clk);
        end
        start = 1'b0; md_op = MD_NONE;
        check("ign_busy", 64'(n), 64'(MC));
        check("ign_hi", 64'(hi), 64'(32'hFFFF_FFFF));
        check("ign_lo", 64'(lo), 64'(32'hFFFF_FFFA));
        @(negedge clk);
        check("ign_idle", 64'(busy), 64'(0));

        // Asynchronous reset in the middle of a window.
        @(negedge clk);
        md_op = MD_MULT; a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = MD_NONE;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_hi", 64'(hi), 64'(0));
        check("arst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (MC + 1) @(negedge clk);
        check("arst_after_busy", 64'(busy), 64'(0));
        check("arst_after_lo", 64'(lo), 64'(0));
        m_hi = '0;
        m_lo = '0;

        run_op(MD_MTHI, 32'd0, 32'd0, 1'b0, 0, 32'd0, 32'd0, "madd_prehi");
        run_op(MD_MTLO, 32'd1, 32'd0, 1'b0, 0, 32'd0, 32'd1, "madd_prelo");
`ifdef MD_UNIT_MADD_EN
        run_op(MD_MADD, 32'd2, 32'd3, 1'b1, MC, 32'd0, 32'd7, "madd");
`else
        run_op(MD_MADD, 32'd2, 32'd3, 1'b1, 0, 32'd0, 32'd1, "madd_off");
`endif

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0: av = 32'h8000_0000;
                1: av = 32'($urandom_range(0, 20));
                2: av = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: av = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: bv = 32'd0;
                1: bv = 32'hFFFF_FFFF;
                2: bv = 32'($urandom_range(1, 9));
                default: bv = $urandom;
            endcase
            st = ($urandom_range(0, 3) != 0);
            model(op, av, bv, st, m_hi, m_lo, en, eh, el);
            run_op(op, av, bv, st, en, eh, el, $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu/mthi/mtlo and serves mfhi/mflo reads from the HI/LO registers.
- Produces the `busy` signal that the stall/forward unit consumes, together with the E-stage `start` pulse, to hold any MD-class instruction in D.
- Models multi-cycle latency: results are computed at `start` and committed to HI/LO at the end of the busy window.

Parameters:
- MULT_CYCLES, 5, busy-window length for mult/multu (and madd-class when enabled); must be >= 1.
- DIV_CYCLES, 10, busy-window length for div/divu; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage MD operation launch; qualified by md_op.
- md_op  input  4  operation code (package constants).
- a  input  32  operand rs (forwarded value).
- b  input  32  operand rt (forwarded value).
- rd_hi  input  1  read select for md_out: 1 selects HI (mfhi), 0 selects LO (mflo).
- busy  output  1  multi-cycle operation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_out  output  32  rd_hi ? hi : lo (combinational).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, hi=0, lo=0, pending regs=0, busy=0. A reset mid-operation aborts it; HI/LO stay 0.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, counter counts down.
- IDLE, start=1, md_op in {MULT, MULTU, DIV, DIVU}:
  - Compute result at the same edge; latch it into hi_pend/lo_pend.
  - Load counter with N-1, where N=MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY: decrement each edge. On the edge where counter==0: hi<=hi_pend, lo<=lo_pend, go to IDLE.
  - busy is therefore high for exactly N cycles after the launch edge.
  - New HI/LO values are visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 32x32 to 64; {hi,lo}=product.
  - multu: unsigned 32x32 to 64; {hi,lo}=product.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (b==0): full DIV_CYCLES busy window still runs; HI/LO keep their old values.
- MTHI/MTLO: when busy=0 and md_op is MTHI/MTLO, hi or lo <= a at the next edge, with no busy window. start is not required for these ops.
- Ignored events:
  - start or MTHI/MTLO while busy=1: ignored; the in-flight operation is unaffected. The stall unit guarantees this does not occur, and the bench checks it is harmless.
  - start with a non-launch md_op (NONE, MTHI, MTLO): no busy window; MTHI/MTLO still act per the rule above.
- md_out reads the current registers. A read in the same cycle as a commit edge returns the old value. The stall unit prevents this case.

Optional Feature:
- Macro MD_UNIT_MADD_EN.
- Defined:
  - Adds md_op MADD, MADDU, MSUB, MSUBU, each with a MULT_CYCLES window.
  - Pending result = {hi,lo} ± product; HI/LO are sampled at the launch edge.
  - Modulo 2^64.
- Undefined: these codes behave as NONE (ignored, no busy window).

Decomposition:
- Package md_pkg holds:
  - md_op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - State encoding: IDLE, BUSY.
  - Default-latency constants.
- One sub-module, md_arith: purely combinational. Takes a, b, op and current {hi,lo}; returns the 64-bit pending result and a div_by_zero flag.
- md_unit keeps the FSM, counter and registers.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3: busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu on the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- div a=-7 (0xFFFFFFF9), b=2: busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 gives lo=3, hi=1.
- Prior hi=0x11, lo=0x22, div with b=0: busy high 10 cycles; hi/lo remain 0x11/0x22.
- mthi a=0xABCD then mtlo a=0x1234 on consecutive idle cycles: hi=0xABCD, lo=0x1234 with no busy; md_out follows rd_hi.
- Launch mult; at cycle 3 pulse start with DIV and apply MTHI: ignored, and the mult result commits on time. In a second run, assert reset low at cycle 2: busy=0, hi=lo=0 immediately (asynchronous).
- Macro defined: hi=0, lo=1, madd a=2, b=3 gives lo=7 after 5 cycles. Macro undefined: the same stimulus gives busy=0 and no change to HI/LO.
